// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The master modport belongs to the controller, and the slave modport belongs to the datapath/memory side.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  // Memory handshake: an access completes in the same cycle that mem_ready is high.
  // The controller holds AdrSrc/MemWrite stable until that cycle.
  logic [6:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       ImmSrc;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, instret
  );

  modport slave (
    output op, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: it sequences fetch/decode/execute/memory/writeback on one shared datapath.
// It also keeps a retired-instruction counter and a sticky illegal-opcode flag.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus,
  output logic [3:0]              state_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic             fetch_q, beq_q, jal_q;
  logic             adr_src_q, mem_write_q, reg_write_q, illegal_q;
  logic [1:0]       result_src_q, alu_src_a_q, alu_src_b_q, alu_op_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that takes the FSM back into FETCH from a final state.
  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                  ((state_q == S_MEMWRITE) && bus.mem_ready);

  // The outputs are decoded from the next state, so each one is a flop that is valid in its own state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      fetch_q      <= 1'b1;
      beq_q        <= 1'b0;
      jal_q        <= 1'b0;
      adr_src_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b10;
      alu_src_a_q  <= 2'b00;
      alu_src_b_q  <= 2'b10;
      alu_op_q     <= 2'b00;
      illegal_q    <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      instret_q    <= instret_q + CNT_W'(retire);
      illegal_q    <= illegal_q | (state_d == S_ILLEGAL);
      fetch_q      <= 1'b0;
      beq_q        <= 1'b0;
      jal_q        <= 1'b0;
      adr_src_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      alu_src_a_q  <= 2'b00;
      alu_src_b_q  <= 2'b00;
      alu_op_q     <= 2'b00;
      case (state_d)
        S_FETCH: begin
          fetch_q      <= 1'b1;
          result_src_q <= 2'b10;
          alu_src_b_q  <= 2'b10;
        end
        S_DECODE: begin
          alu_src_a_q <= 2'b01;
          alu_src_b_q <= 2'b01;
        end
        S_MEMADR: begin
          alu_src_a_q <= 2'b10;
          alu_src_b_q <= 2'b01;
        end
        S_MEMREAD:  adr_src_q <= 1'b1;
        S_MEMWB: begin
          result_src_q <= 2'b01;
          reg_write_q  <= 1'b1;
        end
        S_MEMWRITE: begin
          adr_src_q   <= 1'b1;
          mem_write_q <= 1'b1;
        end
        S_EXECR: begin
          alu_src_a_q <= 2'b10;
          alu_op_q    <= 2'b10;
        end
        S_EXECI: begin
          alu_src_a_q <= 2'b10;
          alu_src_b_q <= 2'b01;
          alu_op_q    <= 2'b10;
        end
        S_ALUWB:    reg_write_q <= 1'b1;
        S_BEQ: begin
          beq_q       <= 1'b1;
          alu_src_a_q <= 2'b10;
          alu_op_q    <= 2'b01;
        end
        S_JAL: begin
          jal_q       <= 1'b1;
          alu_src_a_q <= 2'b01;
          alu_src_b_q <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ImmSrc = 2'b00;
    case (bus.op)
      OP_STORE: bus.ImmSrc = 2'b01;
      OP_BEQ:   bus.ImmSrc = 2'b10;
      OP_JAL:   bus.ImmSrc = 2'b11;
      default:  bus.ImmSrc = 2'b00;
    endcase
  end

  // PC and IR updates must follow this cycle's memory/compare result, so they remain combinational.
  assign bus.PCWrite   = (fetch_q & bus.mem_ready) | (beq_q & bus.zero) | jal_q;
  assign bus.IRWrite   = fetch_q & bus.mem_ready;
  assign bus.AdrSrc    = adr_src_q;
  assign bus.MemWrite  = mem_write_q;
  assign bus.RegWrite  = reg_write_q;
  assign bus.ResultSrc = result_src_q;
  assign bus.ALUSrcA   = alu_src_a_q;
  assign bus.ALUSrcB   = alu_src_b_q;
  assign bus.ALUOp     = alu_op_q;
  assign bus.illegal   = illegal_q;
  assign bus.instret   = instret_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-timeline reference model fills an expected queue.
// Every cycle's control outputs and instret are compared against that queue.
module tb_multicycle_controller;
  localparam int CNT_W  = 32;
  localparam int WRAP_W = 3;
  localparam int EW     = CNT_W + 16;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(CNT_W))  bus ();
  multicycle_controller_if #(.CNT_W(WRAP_W)) wbus ();
  logic [3:0] state_dbg, wstate_dbg;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state_dbg)
  );
  multicycle_controller #(.CNT_W(WRAP_W)) dut_w (
    .clk(clk), .rst(rst), .bus(wbus), .state_o(wstate_dbg)
  );

  logic unused_obs;
  assign unused_obs = ^{state_dbg, wstate_dbg, wbus.PCWrite, wbus.AdrSrc, wbus.MemWrite,
                        wbus.IRWrite, wbus.RegWrite, wbus.ResultSrc, wbus.ALUSrcA,
                        wbus.ALUSrcB, wbus.ALUOp, wbus.ImmSrc, wbus.illegal};

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  logic [8:0]       stim_q[$];   // {op, mem_ready, zero}
  logic [EW-1:0]    exp_q[$];    // {instret, control vector}
  logic [CNT_W-1:0] model_cnt;
  logic             model_illegal;
  logic [6:0]       cur_op;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      OP_LOAD, OP_I: return 2'b00;
      OP_STORE:      return 2'b01;
      OP_BEQ:        return 2'b10;
      OP_JAL:        return 2'b11;
      default:       return 2'b00;
    endcase
  endfunction

  function logic [15:0] mk(input logic pcw, input logic adr, input logic mw, input logic irw,
                           input logic rw, input logic [1:0] rs, input logic [1:0] a,
                           input logic [1:0] b, input logic [1:0] alu);
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm_of(cur_op), model_illegal};
  endfunction

  task automatic push(input logic mr, input logic z, input logic [15:0] c, input bit retire);
    stim_q.push_back({cur_op, mr, z});
    exp_q.push_back({model_cnt, c});
    if (retire) model_cnt = model_cnt + 1'b1;
  endtask

  // One instruction as a cycle timeline. fw = fetch wait cycles, and mw = memory wait cycles.
  // For an illegal opcode, mw is the number of idle cycles observed.
  task automatic model_instr(input logic [6:0] o, input logic zf, input int fw, input int mw);
    logic mr;
    cur_op = o;
    for (int w = 0; w <= fw; w++) begin
      mr = (w == fw);
      push(mr, rb(), mk(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 2'b00), 0);
    end
    push(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00), 0);
    case (o)
      OP_R, OP_I: begin
        push(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == OP_I) ? 2'b01 : 2'b00, 2'b10), 0);
        push(rb(), rb(), mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), 1);
      end
      OP_LOAD: begin
        push(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00), 0);
        for (int w = 0; w <= mw; w++) begin
          mr = (w == mw);
          push(mr, rb(), mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), 0);
        end
        push(rb(), rb(), mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00), 1);
      end
      OP_STORE: begin
        push(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00), 0);
        for (int w = 0; w <= mw; w++) begin
          mr = (w == mw);
          push(mr, rb(), mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), mr);
        end
      end
      OP_BEQ: push(rb(), zf, mk(zf, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01), 1);
      OP_JAL: begin
        push(rb(), rb(), mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00), 0);
        push(rb(), rb(), mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), 1);
      end
      default: begin
        model_illegal = 1'b1;
        for (int w = 0; w < mw; w++)
          push(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), 0);
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_cycle(input logic [8:0] s, output logic [15:0] c,
                             output logic [CNT_W-1:0] n);
    @(negedge clk);
    {bus.op, bus.mem_ready, bus.zero} = s;
    #1;
    c = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
         bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.illegal};
    n = bus.instret;
  endtask

  // This task returns at a falling edge with rst just released, and the FSM is in FETCH.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cur_op = 7'd0;
    {bus.op, bus.mem_ready, bus.zero} = 9'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_cnt = '0;
    model_illegal = 1'b0;
    stim_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  logic [15:0]      obs_c;
  logic [CNT_W-1:0] obs_n;
  logic [EW-1:0]    exp_v;

  task automatic test_reset();
    do_reset();
    #1;
    exp_v = {model_cnt, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00)};
    obs_c = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
             bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.illegal};
    vectors++;
    if ({bus.instret, obs_c} !== exp_v) begin
      miscompares++;
      $display("FAIL reset: got ctrl=%h instret=%0d, want ctrl=%h instret=%0d",
               obs_c, bus.instret, exp_v[15:0], exp_v[EW-1:16]);
    end
  endtask

  task automatic test_rtype();
    model_instr(OP_R, 1'b0, 0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      apply_cycle(stim_q.pop_front(), obs_c, obs_n);
      exp_v = exp_q.pop_front();
      vectors++;
      if ({obs_n, obs_c} !== exp_v) begin
        miscompares++;
        $display("FAIL rtype cyc %0d: got ctrl=%h instret=%0d, want ctrl=%h instret=%0d",
                 k, obs_c, obs_n, exp_v[15:0], exp_v[EW-1:16]);
      end
    end
  endtask

  task automatic test_load_store();
    model_instr(OP_LOAD, 1'b0, 0, 3);
    model_instr(OP_STORE, 1'b0, 1, 2);
    for (int k = 0; exp_q.size() > 0; k++) begin
      apply_cycle(stim_q.pop_front(), obs_c, obs_n);
      exp_v = exp_q.pop_front();
      vectors++;
      if ({obs_n, obs_c} !== exp_v) begin
        miscompares++;
        $display("FAIL load_store cyc %0d: got ctrl=%h instret=%0d, want ctrl=%h instret=%0d",
                 k, obs_c, obs_n, exp_v[15:0], exp_v[EW-1:16]);
      end
    end
  endtask

  task automatic test_branch_jal();
    model_instr(OP_BEQ, 1'b1, 0, 0);
    model_instr(OP_BEQ, 1'b0, 0, 0);
    model_instr(OP_JAL, 1'b0, 0, 0);
    model_instr(OP_I, 1'b0, 0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      apply_cycle(stim_q.pop_front(), obs_c, obs_n);
      exp_v = exp_q.pop_front();
      vectors++;
      if ({obs_n, obs_c} !== exp_v) begin
        miscompares++;
        $display("FAIL branch_jal cyc %0d: got ctrl=%h instret=%0d, want ctrl=%h instret=%0d",
                 k, obs_c, obs_n, exp_v[15:0], exp_v[EW-1:16]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[6];
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BEQ, OP_JAL};
    for (int i = 0; i < 40; i++)
      model_instr(ops[$urandom_range(0, 5)], rb(), $urandom_range(0, 2), $urandom_range(0, 3));
    for (int k = 0; exp_q.size() > 0; k++) begin
      apply_cycle(stim_q.pop_front(), obs_c, obs_n);
      exp_v = exp_q.pop_front();
      vectors++;
      if ({obs_n, obs_c} !== exp_v) begin
        miscompares++;
        $display("FAIL random cyc %0d: got ctrl=%h instret=%0d, want ctrl=%h instret=%0d",
                 k, obs_c, obs_n, exp_v[15:0], exp_v[EW-1:16]);
      end
    end
  endtask

  // Reset lands while a load waits in MEMREAD or a store holds MemWrite.
  task automatic test_reset_mid_access();
    logic [6:0] mops[2];
    mops = '{OP_LOAD, OP_STORE};
    for (int m = 0; m < 2; m++) begin
      model_instr(mops[m], 1'b0, 0, 6);
      for (int k = 0; k < 5; k++) begin
        apply_cycle(stim_q.pop_front(), obs_c, obs_n);
        exp_v = exp_q.pop_front();
        vectors++;
        if ({obs_n, obs_c} !== exp_v) begin
          miscompares++;
          $display("FAIL mid_access op=%b cyc %0d: got ctrl=%h instret=%0d, want ctrl=%h instret=%0d",
                   mops[m], k, obs_c, obs_n, exp_v[15:0], exp_v[EW-1:16]);
        end
      end
      stim_q.delete();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_cnt = '0;
      model_illegal = 1'b0;
      #1;
      exp_v = {model_cnt, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00)};
      obs_c = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
               bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.illegal};
      vectors++;
      if ({bus.instret, obs_c} !== exp_v) begin
        miscompares++;
        $display("FAIL mid_access_rst op=%b: got ctrl=%h instret=%0d, want ctrl=%h instret=%0d",
                 mops[m], obs_c, bus.instret, exp_v[15:0], exp_v[EW-1:16]);
      end
    end
  endtask

  task automatic test_illegal();
    model_instr(OP_R, 1'b0, 0, 0);
    model_instr(OP_BAD, 1'b0, 0, 12);
    for (int k = 0; exp_q.size() > 0; k++) begin
      apply_cycle(stim_q.pop_front(), obs_c, obs_n);
      exp_v = exp_q.pop_front();
      vectors++;
      if ({obs_n, obs_c} !== exp_v) begin
        miscompares++;
        $display("FAIL illegal cyc %0d: got ctrl=%h instret=%0d, want ctrl=%h instret=%0d",
                 k, obs_c, obs_n, exp_v[15:0], exp_v[EW-1:16]);
      end
    end
    do_reset();
    #1;
    exp_v = {model_cnt, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00)};
    obs_c = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
             bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.illegal};
    vectors++;
    if ({bus.instret, obs_c} !== exp_v) begin
      miscompares++;
      $display("FAIL illegal_rst: got ctrl=%h instret=%0d, want ctrl=%h instret=%0d",
               obs_c, bus.instret, exp_v[15:0], exp_v[EW-1:16]);
    end
  endtask

  // The narrow-counter instance runs back-to-back R-types and retires every 4 cycles, so it wraps 7 -> 0.
  task automatic test_wrap();
    logic [WRAP_W-1:0] want;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      want = WRAP_W'((k / 4) % (1 << WRAP_W));
      vectors++;
      if (wbus.instret !== want) begin
        miscompares++;
        $display("FAIL wrap cyc %0d: got instret=%0d, want %0d", k, wbus.instret, want);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wbus.op = OP_R;
    wbus.mem_ready = 1'b1;
    wbus.zero = 1'b0;
    {bus.op, bus.mem_ready, bus.zero} = 9'd0;
    model_cnt = '0;
    model_illegal = 1'b0;
    cur_op = 7'd0;
    test_reset();
    test_rtype();
    test_load_store();
    test_branch_jal();
    test_random();
    test_reset_mid_access();
    test_rtype();
    test_illegal();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
